// File: rtl/bs_pkg.sv
// rtl/bs_pkg.sv - shared types and widths for the Black-Scholes core dispatcher
package bs_pkg;

  localparam int BS_PACK_W = 192;
  localparam int BS_RES_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    HOLD
  } core_state_t;

  // Core index width: ceil(log2(n)), never narrower than one bit
  function automatic int bs_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bs_dispatcher_if.sv
// rtl/bs_dispatcher_if.sv - packet, core-control and result signals of the dispatcher
interface bs_dispatcher_if import bs_pkg::*; #(
  parameter int BSMODS = 2,
  parameter int PACK_W = BS_PACK_W,
  parameter int RES_W  = BS_RES_W,
  parameter int CW     = bs_idx_w(BSMODS)
);

  logic                    in_valid;
  logic                    in_ready;
  logic [PACK_W-1:0]       in_data;

  logic [PACK_W-1:0]       full_pack_out;
  logic [BSMODS-1:0]       reg_en;
  logic [BSMODS-1:0]       bs_start;
  logic [BSMODS-1:0]       bs_ready;
  logic [BSMODS-1:0]       bs_done;
  logic [BSMODS-1:0]       bs_idle;
  logic [BSMODS*RES_W-1:0] ap_return;

  logic                    out_valid;
  logic                    out_ready;
  logic [RES_W-1:0]        out_data;
  logic [CW-1:0]           out_core;

  modport master (
    input  in_valid, in_data, bs_ready, bs_done, bs_idle, ap_return, out_ready,
    output in_ready, full_pack_out, reg_en, bs_start, out_valid, out_data, out_core
  );

  modport slave (
    output in_valid, in_data, bs_ready, bs_done, bs_idle, ap_return, out_ready,
    input  in_ready, full_pack_out, reg_en, bs_start, out_valid, out_data, out_core
  );

endinterface

// File: rtl/bs_order_fifo.sv
// rtl/bs_order_fifo.sv - issue-order FIFO of core indices with simultaneous push/pop
module bs_order_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bs_dispatcher.sv
// rtl/bs_dispatcher.sv - round-robin Black-Scholes core scheduler, in-order retirement; optional BS_DISPATCH_STATS_EN
module bs_dispatcher import bs_pkg::*; #(
  parameter int BSMODS = 2,
  parameter int PACK_W = BS_PACK_W,
  parameter int RES_W  = BS_RES_W,
  parameter int CW     = bs_idx_w(BSMODS)
) (
  input  logic             clock,
  input  logic             reset,
  bs_dispatcher_if.master  bus,
  output logic             busy
`ifdef BS_DISPATCH_STATS_EN
  ,
  output logic [31:0]      issued_cnt,
  output logic [31:0]      retired_cnt
`endif
);

  core_state_t       state_q [BSMODS];
  core_state_t       state_d [BSMODS];
  logic [RES_W-1:0]  slot_q  [BSMODS];
  logic [BSMODS-1:0] capture;
  logic [PACK_W-1:0] pack_q;
  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     sel_idx;
  logic [CW-1:0]     head;
  logic              sel_found;
  logic              any_idle;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              retire;

  // Core occupancy summary
  always_comb begin
    any_idle = 1'b0;
    busy     = 1'b0;
    for (int k = 0; k < BSMODS; k++) begin
      if (state_q[k] == IDLE) any_idle = 1'b1;
      else                    busy     = 1'b1;
    end
  end

  // First idle core at or after rr_ptr, wrapping around
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < BSMODS; i++) begin
      if (!sel_found && state_q[(int'(rr_ptr) + i) % BSMODS] == IDLE) begin
        sel_found = 1'b1;
        sel_idx   = CW'((int'(rr_ptr) + i) % BSMODS);
      end
    end
  end

  // Readiness comes from registered state only; held low while reset is applied
  assign bus.in_ready  = !reset && any_idle && !fifo_full;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !fifo_empty && (state_q[head] == HOLD);
  assign retire        = bus.out_valid && bus.out_ready;
  assign bus.out_data  = slot_q[head];
  assign bus.out_core  = head;
  assign bus.full_pack_out = pack_q;

  // Per-core next state, result capture and core strobes
  always_comb begin
    capture      = '0;
    bus.reg_en   = '0;
    bus.bs_start = '0;
    for (int k = 0; k < BSMODS; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        IDLE:  if (accept && sel_idx == CW'(k)) state_d[k] = LOAD;
        LOAD:  begin
          bus.reg_en[k] = 1'b1;
          state_d[k]    = START;
        end
        START: begin
          bus.bs_start[k] = 1'b1;
          if (bus.bs_ready[k]) begin
            if (bus.bs_done[k]) begin
              capture[k] = 1'b1;
              state_d[k] = HOLD;
            end else begin
              state_d[k] = RUN;
            end
          end
        end
        RUN:   if (bus.bs_done[k]) begin
          capture[k] = 1'b1;
          state_d[k] = HOLD;
        end
        HOLD:  if (retire && head == CW'(k)) state_d[k] = IDLE;
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Core state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < BSMODS; k++) state_q[k] <= IDLE;
    end else begin
      for (int k = 0; k < BSMODS; k++) state_q[k] <= state_d[k];
    end
  end

  // Packet bus latch, round-robin pointer and result slots
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pack_q <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < BSMODS; k++) slot_q[k] <= '0;
    end else begin
      if (accept) begin
        pack_q <= bus.in_data;
        rr_ptr <= (sel_idx == CW'(BSMODS - 1)) ? '0 : sel_idx + 1'b1;
      end
      for (int k = 0; k < BSMODS; k++) begin
        if (capture[k]) slot_q[k] <= bus.ap_return[k*RES_W +: RES_W];
      end
    end
  end

  bs_order_fifo #(
    .DEPTH (BSMODS),
    .W     (CW)
  ) u_order (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (sel_idx),
    .pop       (retire),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef BS_DISPATCH_STATS_EN
  // Free-running issue/retire counters, wrapping at 2^32
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_cnt  <= '0;
      retired_cnt <= '0;
    end else begin
      if (accept) issued_cnt  <= issued_cnt + 32'd1;
      if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bs_dispatcher.sv
// tb/tb_bs_dispatcher.sv - directed and randomized checks of bs_dispatcher
module tb_bs_dispatcher;
  import bs_pkg::*;

  localparam int N  = 2;
  localparam int PW = 192;
  localparam int RW = 32;
  localparam int CW = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
`ifdef BS_DISPATCH_STATS_EN
  logic [31:0] issued_cnt;
  logic [31:0] retired_cnt;
`endif

  bs_dispatcher_if #(.BSMODS(N), .PACK_W(PW), .RES_W(RW), .CW(CW)) bus ();

  bs_dispatcher #(.BSMODS(N), .PACK_W(PW), .RES_W(RW), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef BS_DISPATCH_STATS_EN
    ,
    .issued_cnt  (issued_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          core;
    logic [31:0] res;
  } exp_t;

  exp_t        q[$];
  int          rr_m;
  bit          busy_m  [N];
  bit          done_m  [N];
  int          phase   [N];
  int          rdy_cnt [N];
  int          dn_cnt  [N];
  logic [31:0] res_m   [N];
  bit          done_now[N];
  int          iss_m;
  int          ret_m;
  bit          any_free;
  bit          exp_ov;
  bit          acc;
  bit          ret;
  int          acc_core;
  logic [PW-1:0] rnd_data;
  logic [31:0]   rnd_res;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.bs_ready  = '0;
    bus.bs_done   = '0;
    bus.bs_idle   = '1;
    bus.ap_return = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic set_ret(input int k, input logic [31:0] v);
    bus.ap_return[k*RW +: RW] = v;
  endtask

  initial begin
    // reset values
    clear_inputs();
    cyc();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_reg_en", bus.reg_en, 0);
    check("rst_bs_start", bus.bs_start, 0);
    check("rst_pack", bus.full_pack_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_core", bus.out_core, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    cyc();
    check("rel_in_ready", bus.in_ready, 1);

    // single packet, ready and done together
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 192'h1;
    cyc();
    bus.in_valid = 1'b0;
    check("single_reg_en", bus.reg_en, 2'b01);
    check("single_pack", bus.full_pack_out, 192'h1);
    check("single_start_early", bus.bs_start, 0);
    cyc();
    check("single_bs_start", bus.bs_start, 2'b01);
    check("single_reg_en_drop", bus.reg_en, 0);
    bus.bs_ready = 2'b01;
    bus.bs_done  = 2'b01;
    set_ret(0, 32'hCAFE);
    cyc();
    bus.bs_ready = '0;
    bus.bs_done  = '0;
    check("single_start_drop", bus.bs_start, 0);
    check("single_out_valid", bus.out_valid, 1);
    check("single_out_data", bus.out_data, 32'hCAFE);
    check("single_out_core", bus.out_core, 0);
    check("single_busy", busy, 1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("single_retired", bus.out_valid, 0);
    check("single_idle", busy, 0);

    // out-of-order completion retires in issue order
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 192'hA;
    cyc();
    bus.in_data  = 192'hB;
    cyc();
    bus.in_valid = 1'b0;
    check("ooo_reg_en_b", bus.reg_en, 2'b10);
    check("ooo_pack_b", bus.full_pack_out, 192'hB);
    cyc();
    check("ooo_both_start", bus.bs_start, 2'b11);
    bus.bs_ready = 2'b11;
    bus.bs_done  = 2'b10;
    set_ret(1, 32'h0000_000B);
    cyc();
    bus.bs_ready = '0;
    bus.bs_done  = '0;
    for (int i = 0; i < 10; i++) begin
      check("ooo_b_waits", bus.out_valid, 0);
      cyc();
    end
    bus.bs_done = 2'b01;
    set_ret(0, 32'h0000_000A);
    cyc();
    bus.bs_done = '0;
    check("ooo_a_valid", bus.out_valid, 1);
    check("ooo_a_data", bus.out_data, 32'hA);
    check("ooo_a_core", bus.out_core, 0);
    bus.out_ready = 1'b1;
    cyc();
    check("ooo_b_valid", bus.out_valid, 1);
    check("ooo_b_data", bus.out_data, 32'hB);
    check("ooo_b_core", bus.out_core, 1);
    cyc();
    bus.out_ready = 1'b0;
    check("ooo_drained", bus.out_valid, 0);

    // backpressure and round-robin wrap
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 192'hC;
    cyc();
    bus.in_data  = 192'hD;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    bus.bs_ready = 2'b11;
    bus.bs_done  = 2'b11;
    set_ret(0, 32'h0C);
    set_ret(1, 32'h0D);
    cyc();
    bus.bs_ready = '0;
    bus.bs_done  = '0;
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("bp_in_ready_back", bus.in_ready, 1);
    check("bp_head_core1", bus.out_core, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 192'hE;
    cyc();
    bus.in_valid = 1'b0;
    check("bp_wrap_core0", bus.reg_en, 2'b01);

    // ap_start held until ready
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 192'h55;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    check("hold_start_rise", bus.bs_start, 2'b01);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_start_high", bus.bs_start, 2'b01);
    end
    bus.bs_ready = 2'b01;
    cyc();
    bus.bs_ready = '0;
    check("hold_start_drop", bus.bs_start, 0);
    check("hold_run_no_valid", bus.out_valid, 0);
    bus.bs_done = 2'b01;
    set_ret(0, 32'h1234_5678);
    cyc();
    bus.bs_done = '0;
    check("hold_result", bus.out_data, 32'h1234_5678);

    // reset while core0 runs and core1 holds
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 192'hA;
    cyc();
    bus.in_data  = 192'hB;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    bus.bs_ready = 2'b11;
    bus.bs_done  = 2'b10;
    set_ret(1, 32'hBEEF);
    cyc();
    bus.bs_ready = '0;
    bus.bs_done  = '0;
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_in_ready", bus.in_ready, 0);
    check("mid_reg_en", bus.reg_en, 0);
    check("mid_bs_start", bus.bs_start, 0);
    check("mid_pack", bus.full_pack_out, 0);
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_out_data", bus.out_data, 0);
    check("mid_out_core", bus.out_core, 0);
    check("mid_busy_clear", busy, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("mid_in_ready_back", bus.in_ready, 1);
    bus.bs_done = 2'b01;
    set_ret(0, 32'hDEAD);
    cyc();
    bus.bs_done = '0;
    for (int i = 0; i < 3; i++) begin
      check("mid_late_done_valid", bus.out_valid, 0);
      check("mid_late_done_busy", busy, 0);
      cyc();
    end

    // randomized traffic against an issue-order model
    do_reset();
    q.delete();
    rr_m  = 0;
    iss_m = 0;
    ret_m = 0;
    for (int k = 0; k < N; k++) begin
      busy_m[k] = 1'b0;
      done_m[k] = 1'b0;
      phase[k]  = 3;
    end
    for (int it = 0; it < 400; it++) begin
      any_free = 1'b0;
      for (int k = 0; k < N; k++) if (!busy_m[k]) any_free = 1'b1;
      exp_ov = (q.size() > 0) && done_m[q[0].core];
      check("rnd_in_ready", bus.in_ready, any_free);
      check("rnd_out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
        check("rnd_out_data", bus.out_data, q[0].res);
        check("rnd_out_core", bus.out_core, q[0].core);
      end

      bus.in_valid = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < 6; w++) rnd_data[w*32 +: 32] = $urandom();
      bus.in_data   = rnd_data;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      acc = bus.in_valid && any_free;
      ret = exp_ov && bus.out_ready;

      // core responders
      for (int k = 0; k < N; k++) begin
        bus.bs_ready[k] = 1'b0;
        bus.bs_done[k]  = 1'b0;
        done_now[k]     = 1'b0;
        if (phase[k] == 0 && bus.bs_start[k]) begin
          if (rdy_cnt[k] > 0) begin
            rdy_cnt[k]--;
          end else begin
            bus.bs_ready[k] = 1'b1;
            if (dn_cnt[k] == 0) begin
              bus.bs_done[k] = 1'b1;
              set_ret(k, res_m[k]);
              done_now[k] = 1'b1;
              phase[k]    = 3;
            end else begin
              phase[k] = 2;
            end
          end
        end else if (phase[k] == 2) begin
          check("rnd_start_dropped", bus.bs_start[k], 0);
          dn_cnt[k]--;
          if (dn_cnt[k] == 0) begin
            bus.bs_done[k] = 1'b1;
            set_ret(k, res_m[k]);
            done_now[k] = 1'b1;
            phase[k]    = 3;
          end
        end
      end

      acc_core = 0;
      if (acc) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (!busy_m[(rr_m + i) % N]) acc_core = (rr_m + i) % N;
        end
        rnd_res = $urandom();
        q.push_back('{core: acc_core, res: rnd_res});
        busy_m[acc_core]  = 1'b1;
        rr_m              = (acc_core + 1) % N;
        phase[acc_core]   = 0;
        rdy_cnt[acc_core] = $urandom_range(0, 3);
        dn_cnt[acc_core]  = $urandom_range(0, 6);
        res_m[acc_core]   = rnd_res;
        iss_m++;
      end
      if (ret) begin
        busy_m[q[0].core] = 1'b0;
        done_m[q[0].core] = 1'b0;
        void'(q.pop_front());
        ret_m++;
      end
      for (int k = 0; k < N; k++) if (done_now[k]) done_m[k] = 1'b1;

      cyc();
      check("rnd_reg_en", bus.reg_en, acc ? (2'b01 << acc_core) : 2'b00);
      if (acc) check("rnd_pack", bus.full_pack_out, rnd_data);
    end
    clear_inputs();
`ifdef BS_DISPATCH_STATS_EN
    check("stats_issued", issued_cnt, iss_m);
    check("stats_retired", retired_cnt, ret_m);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
